// File: rtl/bus_transfer_sequencer.sv
// Initiator for a single source-to-destination move on the shared tri-state bus.
// Runs drive -> settle -> capture -> hold -> release so only one source ever drives.
module bus_transfer_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_src,
    input  logic [1:0] req_dst,
    input  logic [7:0] bus_in,
    output logic [3:0] oe_n,
    output logic [3:0] cp,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] bus_data
);

    typedef enum logic [2:0] {
        IDLE,
        REJECT,
        DRIVE,
        LATCH,
        HOLD
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] src_q, src_d;
    logic [1:0] dst_q, dst_d;
    logic [3:0] oe_n_q, oe_n_d;
    logic [3:0] cp_q, cp_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [7:0] bus_data_q, bus_data_d;
    logic [3:0] src_hot, dst_hot;

    assign req_ready = (state_q == IDLE) && !rst;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        src_d      = src_q;
        dst_d      = dst_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        bus_data_d = bus_data_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    src_d = req_src;
                    dst_d = req_dst;
                    if (req_src != req_dst) begin
                        state_d = DRIVE;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = REJECT;
                    end
                end
            end
            REJECT: begin
                state_d = IDLE;
                done_d  = 1'b1;
                err_d   = 1'b1;
            end
            DRIVE: begin
                if (cnt_q == 4'd0) begin
                    state_d = LATCH;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            LATCH: begin
                state_d    = HOLD;
                bus_data_d = bus_in;
            end
            HOLD: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_decode
        assign src_hot[gi] = (src_d == 2'(gi));
        assign dst_hot[gi] = (dst_d == 2'(gi));
    end

    // Bus-side outputs are decoded from the upcoming state so they change on the same edge.
    always_comb begin
        oe_n_d = 4'b1111;
        cp_d   = 4'b0000;
        busy_d = 1'b0;
        case (state_d)
            REJECT: busy_d = 1'b1;
            DRIVE, HOLD: begin
                oe_n_d = ~src_hot;
                busy_d = 1'b1;
            end
            LATCH: begin
                oe_n_d = ~src_hot;
                cp_d   = dst_hot;
                busy_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            src_q      <= 2'd0;
            dst_q      <= 2'd0;
            oe_n_q     <= 4'b1111;
            cp_q       <= 4'b0000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            bus_data_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            oe_n_q     <= oe_n_d;
            cp_q       <= cp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            bus_data_q <= bus_data_d;
        end
    end

    assign oe_n     = oe_n_q;
    assign cp       = cp_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign bus_data = bus_data_q;

endmodule
